// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single memory port.
//
// Each requester holds req_n high until it sees a one-cycle done_n pulse.
// A granted access stays on the memory interface until mem_resp is seen or
// the timeout counter expires; in the timeout case err_n accompanies done_n.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   req0/1, we0/1         request level and write(1)/read(0) select
//   addr0/1, wdata0/1     per-requester address and write data
//   done0/1, err0/1       completion pulse and timeout flag (valid with done)
//   rdata0/1              last read data captured for each requester
//   mem_re, mem_we        memory strobes (mutually exclusive)
//   mem_addr, mem_wdata   registered address / write data of the granted access
//   mem_rdata, mem_resp   memory read data and completion
//   busy                  high whenever the arbiter is not idle
module mem_arbiter #(
  parameter int ADDR_W  = 14,
  parameter int WDATA_W = 16,
  parameter int RDATA_W = 8,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic               we0,
  input  logic               we1,
  input  logic [ADDR_W-1:0]  addr0,
  input  logic [ADDR_W-1:0]  addr1,
  input  logic [WDATA_W-1:0] wdata0,
  input  logic [WDATA_W-1:0] wdata1,
  output logic               done0,
  output logic               done1,
  output logic               err0,
  output logic               err1,
  output logic [RDATA_W-1:0] rdata0,
  output logic [RDATA_W-1:0] rdata1,
  output logic               mem_re,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WDATA_W-1:0] mem_wdata,
  input  logic [RDATA_W-1:0] mem_rdata,
  input  logic               mem_resp,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // The counter value seen in the last permitted ACCESS cycle; one more
  // cycle without a response means TIMEOUT strobe cycles have elapsed.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     next_state;
  logic       grant;      // granted port, doubles as the round-robin history
  logic       op_we;      // operation latched at grant time
  logic       timed_out;  // DONE was reached through the timeout path
  logic [7:0] cnt;
  logic       winner;
  logic       timeout_hit;

  // State register; reset drops straight to IDLE so strobes fall at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode, arbitration and output decode. The winner favours the
  // port not granted last only when both request together.
  always_comb begin
    next_state  = state;
    winner      = 1'b0;
    timeout_hit = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    done0       = 1'b0;
    done1       = 1'b0;
    err0        = 1'b0;
    err1        = 1'b0;
    busy        = (state != IDLE);

    if (req0 && req1) begin
      winner = ~grant;
    end else if (req1) begin
      winner = 1'b1;
    end

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        mem_re = ~op_we;
        mem_we = op_we;
        // A response in the same cycle as expiry takes priority.
        timeout_hit = ~mem_resp && (cnt == CNT_LAST);
        if (mem_resp || timeout_hit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done0      = ~grant;
        done1      = grant;
        err0       = ~grant & timed_out;
        err1       = grant & timed_out;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: latch the winner's request on grant, count unanswered ACCESS
  // cycles, and capture read data into the granted port's register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant     <= 1'b1;
      op_we     <= 1'b0;
      timed_out <= 1'b0;
      cnt       <= 8'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant     <= winner;
            op_we     <= winner ? we1 : we0;
            mem_addr  <= winner ? addr1 : addr0;
            mem_wdata <= winner ? wdata1 : wdata0;
            cnt       <= 8'd0;
            timed_out <= 1'b0;
          end
        end
        ACCESS: begin
          if (mem_resp) begin
            if (!op_we) begin
              if (grant) begin
                rdata1 <= mem_rdata;
              end else begin
                rdata0 <= mem_rdata;
              end
            end
          end else if (timeout_hit) begin
            timed_out <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 14, address width; WDATA_W, 16, write data width; RDATA_W, 8, read data width; TIMEOUT, 255, max cycles awaiting mem_resp (1..255).
REQ-002 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 req0, req1  in  1 each  requester n access request; level, held until done_n.
REQ-006 we0, we1  in  1 each  requester n write (1) / read (0) select, valid while req_n high.
REQ-007 addr0, addr1  in  ADDR_W each  requester n address.
REQ-008 wdata0, wdata1  in  WDATA_W each  requester n write data.
REQ-009 done0, done1  out  1 each  one-cycle completion pulse to requester n.
REQ-010 err0, err1  out  1 each  timeout flag, valid only while done_n high.
REQ-011 rdata0, rdata1  out  RDATA_W each  read data for requester n; holds last captured value.
REQ-012 mem_re, mem_we  out  1 each  memory read/write strobes; never both high.
REQ-013 mem_addr  out  ADDR_W  registered memory address.
REQ-014 mem_wdata  out  WDATA_W  registered memory write data.
REQ-015 mem_rdata  in  RDATA_W  memory read data, valid when mem_resp high.
REQ-016 mem_resp  in  1  memory completion, sampled only in ACCESS.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 FSM SHALL have states IDLE, ACCESS, DONE; IDLE->ACCESS when req0|req1; ACCESS->DONE on mem_resp or timeout; DONE->IDLE unconditionally.
REQ-019 In IDLE, grant SHALL go to the sole requester if only one req high; on simultaneous req0 and req1, to the port not granted last (round-robin).
REQ-020 last_grant SHALL update on every IDLE->ACCESS transition; reset value selects port 1, so port 0 wins the first tie.
REQ-021 On IDLE->ACCESS, mem_addr, mem_wdata, operation and granted port SHALL be registered from the winner's inputs; later input changes ignored until next grant.
REQ-022 In ACCESS exactly one of mem_re (read) or mem_we (write) SHALL be high, held every cycle until the cycle mem_resp is sampled high inclusive.
REQ-023 On a read, mem_rdata SHALL be captured into rdata of the granted port on the edge where mem_resp is sampled; other port's rdata unchanged; writes leave both rdata unchanged.
REQ-024 In DONE, done of the granted port SHALL be high for exactly one cycle; strobes low; other done low.
REQ-025 Latency: req sampled at edge E -> strobe high from E; mem_resp sampled at edge E+k (k>=0) -> done high cycle after E+k; IDLE one cycle later; minimum req-to-done 2 cycles.
REQ-026 Timeout counter SHALL clear on entry to ACCESS, increment each ACCESS cycle without mem_resp; reaching TIMEOUT SHALL force DONE with err of granted port high, strobes dropped, rdata unchanged.
REQ-027 mem_resp and timeout in same cycle: mem_resp wins, err low.
REQ-028 req deasserted mid-ACCESS SHALL NOT abort; access completes and done still pulses.
REQ-029 req sampled in DONE SHALL be ignored; a requester still high in the following IDLE is re-arbitrated as a new request.
REQ-030 mem_resp outside ACCESS SHALL be ignored.

Reset
REQ-031 reset high SHALL immediately force state IDLE, all outputs 0 (done, err, rdata, mem_re, mem_we, mem_addr, mem_wdata, busy), counter 0, last_grant port 1.
REQ-032 reset asserted mid-ACCESS SHALL drop strobes asynchronously with no done pulse; operation is lost.

Verification
REQ-033 Single read: req0=1, we0=0, addr0=0x0123; mem_resp after 2 cycles with mem_rdata=0xA5 -> mem_re high 3 cycles, mem_addr=0x0123, done0 one pulse, rdata0=0xA5, err0=0.
REQ-034 Single write: req1=1, we1=1, addr1=0x3FFF, wdata1=0xBEEF; immediate mem_resp -> mem_we 1 cycle, mem_wdata=0xBEEF, done1 next cycle, rdata1 unchanged.
REQ-035 Tie round-robin: req0 and req1 both held continuously from reset -> grant order 0,1,0,1; each done pulse 1 cycle; mem_re and mem_we never both high.
REQ-036 Timeout: TIMEOUT=4, req0 read, mem_resp never -> mem_re high 4 cycles, done0 and err0 high together one cycle, rdata0 unchanged.
REQ-037 Reset mid-op: assert reset during ACCESS for port 1 -> all outputs 0 same cycle, no done1; after release, tie grants port 0 first.
REQ-038 Stray/late response: mem_resp pulsed in IDLE and DONE -> no state change, no done, rdata unchanged.
